load_store_unit: RTL and testbench

Initiator-side bus unit between the core's execute stage and the program/data memory. Accepts one load or store request at a time and issues word-aligned reads or byte-lane-strobed writes. Lines up store data with the target byte lanes, and extracts and sign/zero-extends load data from the memory's registered read word. Flags misaligned or illegal accesses without touching memory.

---
 rtl/lsu_pkg.sv | 36 +++
 rtl/lsu_lane_align.sv | 57 +++++
 rtl/load_store_unit.sv | 109 ++++++++++
 tb/tb_load_store_unit.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM encoding
// and the request legality check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } lsu_state_e;

  // Stores only have B/H/W; any wider code, or a misaligned H/W, is an error.
  function automatic logic access_err(input logic we, input logic [2:0] f3,
                                      input logic [1:0] addr_lo);
    logic err;
    err = 1'b0;
    if (we && (f3 > F3_W)) begin
      err = 1'b1;
    end else begin
      case (f3)
        F3_B, F3_BU: err = 1'b0;
        F3_H, F3_HU: err = addr_lo[0];
        F3_W:        err = (addr_lo != 2'b00);
        default:     err = 1'b1;
      endcase
    end
    return err;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store data replication, write-strobe mask and load
// extract/extend from the memory read word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] wdata_rep,
  output logic [3:0]  wr_mask,
  output logic [31:0] rdata_ext
);

  function automatic logic [31:0] replicate(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    case (f3)
      F3_B:    r = {4{d[7:0]}};
      F3_H:    r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] strobe_mask(input logic [2:0] f3, input logic [1:0] lo);
    logic [3:0] m;
    case (f3)
      F3_B:    m = 4'b0001 << lo;
      F3_H:    m = 4'b0011 << {lo[1], 1'b0};
      F3_W:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] lo,
                                          input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = d[{lo, 3'b000} +: 8];
    h = d[{lo[1], 4'b0000} +: 16];
    case (f3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_BU:   r = {24'd0, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_HU:   r = {16'd0, h};
      default: r = d;
    endcase
    return r;
  endfunction

  assign wdata_rep = replicate(funct3, wdata);
  assign wr_mask   = strobe_mask(funct3, addr_lo);
  assign rdata_ext = extract(funct3, addr_lo, rdata);

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store bus initiator: latches one request, issues a
// read or strobed write, and returns an extended load word or an error flag.
//
// state | meaning
// IDLE  | ready for a request
// ISSUE | strobe driven to memory for one cycle
// WAIT  | load only: memory word arrives, captured on exit
// DONE  | resp_valid pulse
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_rd_strobe,
  output logic [3:0]        mem_wr_strobe,
  input  logic [31:0]       mem_rdata
);

  lsu_state_e        state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [31:0]       wdata_q;
  logic              accept;
  logic              req_err;
  logic [31:0]       wdata_rep;
  logic [31:0]       rdata_ext;
  logic [3:0]        wr_mask;

  assign req_ready = (state == IDLE) & ~rst;
  assign accept    = req_valid & req_ready;
  assign req_err   = access_err(req_we, req_funct3, req_addr[1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    resp_valid    = 1'b0;
    mem_rd_strobe = 1'b0;
    mem_wr_strobe = 4'b0000;
    case (state)
      IDLE: begin
        if (accept) state_nxt = req_err ? DONE : ISSUE;
      end
      ISSUE: begin
        mem_rd_strobe = ~we_q;
        mem_wr_strobe = we_q ? wr_mask : 4'b0000;
        state_nxt     = we_q ? DONE : WAIT;
      end
      WAIT: state_nxt = DONE;
      DONE: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Response is cleared on accept so stores and errors report zero data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      we_q       <= 1'b0;
      f3_q       <= 3'b000;
      wdata_q    <= 32'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else if (accept) begin
      addr_q     <= req_addr;
      we_q       <= req_we;
      f3_q       <= req_funct3;
      wdata_q    <= req_wdata;
      resp_rdata <= 32'd0;
      resp_err   <= req_err;
    end else if (state == WAIT) begin
      resp_rdata <= rdata_ext;
    end
  end

  lsu_lane_align u_lane_align (
    .funct3    (f3_q),
    .addr_lo   (addr_q[1:0]),
    .wdata     (wdata_q),
    .rdata     (mem_rdata),
    .wdata_rep (wdata_rep),
    .wr_mask   (wr_mask),
    .rdata_ext (rdata_ext)
  );

  assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_wdata = wdata_rep;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table against a small word memory,
// plus back-to-back and asynchronous-reset sequences.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rd_strobe;
  logic [3:0]  mem_wr_strobe;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:63];

  int checks;
  int failures;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_rd;
    logic [3:0]  exp_wr;
    logic [31:0] exp_wdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs [0:21];

  load_store_unit #(.ADDR_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_funct3    (req_funct3),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_err      (resp_err),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rd_strobe (mem_rd_strobe),
    .mem_wr_strobe (mem_wr_strobe),
    .mem_rdata     (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read memory with byte write enables.
  always @(posedge clk) begin
    if (mem_rd_strobe) mem_rdata <= mem[mem_addr[7:2]];
    for (int b = 0; b < 4; b++)
      if (mem_wr_strobe[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] exp_rdata,
                              input logic exp_err, input logic exp_rd, input logic [3:0] exp_wr,
                              input logic [31:0] exp_wdata, input int exp_lat);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_rd = exp_rd;
    v.exp_wr = exp_wr; v.exp_wdata = exp_wdata; v.exp_lat = exp_lat;
    return v;
  endfunction

  task automatic wait_ready(input string name);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check({name, "_ready_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string       nm;
    int          lat;
    bit          got;
    logic        rd1, rd_any;
    logic [3:0]  wr1, wr_any;
    logic [31:0] addr1, wd1;
    nm = $sformatf("v%0d", idx);
    wait_ready(nm);
    req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3;
    req_addr = v.addr; req_wdata = v.wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rd1 = mem_rd_strobe; wr1 = mem_wr_strobe; addr1 = mem_addr; wd1 = mem_wdata;
    rd_any = 1'b0; wr_any = 4'b0000; lat = 0; got = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      rd_any = rd_any | mem_rd_strobe;
      wr_any = wr_any | mem_wr_strobe;
      if (resp_valid) begin
        got = 1'b1;
        lat = c;
        break;
      end
      @(negedge clk);
    end
    check({nm, "_resp_seen"}, {31'd0, got}, 32'd1);
    check({nm, "_latency"}, lat, v.exp_lat);
    check({nm, "_rdata"}, resp_rdata, v.exp_rdata);
    check({nm, "_err"}, {31'd0, resp_err}, {31'd0, v.exp_err});
    check({nm, "_rd_strobe_c1"}, {31'd0, rd1}, {31'd0, v.exp_rd});
    check({nm, "_wr_strobe_c1"}, {28'd0, wr1}, {28'd0, v.exp_wr});
    check({nm, "_rd_strobe_any"}, {31'd0, rd_any}, {31'd0, v.exp_rd});
    check({nm, "_wr_strobe_any"}, {28'd0, wr_any}, {28'd0, v.exp_wr});
    if (!v.exp_err) check({nm, "_mem_addr"}, addr1, {v.addr[31:2], 2'b00});
    if (v.we && !v.exp_err) check({nm, "_mem_wdata"}, wd1, v.exp_wdata);
    @(negedge clk);
  endtask

  initial begin
    int n_acc, first, second, resp_st, resp_ld, nresp;
    logic [31:0] ld_data;

    checks = 0; failures = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    mem[4] = 32'h8899AABB;
    mem_rdata = 32'd0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'd0; req_wdata = 32'd0;

    //         we    f3      addr       wdata         rdata         err   rd    wr       wdata         lat
    vecs[0]  = mk(1'b0, 3'b000, 32'h13, 32'h0,        32'hFFFFFF88, 1'b0, 1'b1, 4'b0000, 32'h0,        3);
    vecs[1]  = mk(1'b0, 3'b100, 32'h13, 32'h0,        32'h00000088, 1'b0, 1'b1, 4'b0000, 32'h0,        3);
    vecs[2]  = mk(1'b0, 3'b001, 32'h12, 32'h0,        32'hFFFF8899, 1'b0, 1'b1, 4'b0000, 32'h0,        3);
    vecs[3]  = mk(1'b0, 3'b101, 32'h10, 32'h0,        32'h0000AABB, 1'b0, 1'b1, 4'b0000, 32'h0,        3);
    vecs[4]  = mk(1'b0, 3'b010, 32'h10, 32'h0,        32'h8899AABB, 1'b0, 1'b1, 4'b0000, 32'h0,        3);
    vecs[5]  = mk(1'b0, 3'b000, 32'h10, 32'h0,        32'hFFFFFFBB, 1'b0, 1'b1, 4'b0000, 32'h0,        3);
    vecs[6]  = mk(1'b0, 3'b100, 32'h11, 32'h0,        32'h000000AA, 1'b0, 1'b1, 4'b0000, 32'h0,        3);
    vecs[7]  = mk(1'b0, 3'b101, 32'h12, 32'h0,        32'h00008899, 1'b0, 1'b1, 4'b0000, 32'h0,        3);
    vecs[8]  = mk(1'b1, 3'b000, 32'h21, 32'h123456C3, 32'h0,        1'b0, 1'b0, 4'b0010, 32'hC3C3C3C3, 2);
    vecs[9]  = mk(1'b0, 3'b010, 32'h20, 32'h0,        32'h0000C300, 1'b0, 1'b1, 4'b0000, 32'h0,        3);
    vecs[10] = mk(1'b1, 3'b001, 32'h26, 32'h0000BEEF, 32'h0,        1'b0, 1'b0, 4'b1100, 32'hBEEFBEEF, 2);
    vecs[11] = mk(1'b0, 3'b010, 32'h24, 32'h0,        32'hBEEF0000, 1'b0, 1'b1, 4'b0000, 32'h0,        3);
    vecs[12] = mk(1'b1, 3'b010, 32'h28, 32'hCAFEF00D, 32'h0,        1'b0, 1'b0, 4'b1111, 32'hCAFEF00D, 2);
    vecs[13] = mk(1'b0, 3'b001, 32'h2A, 32'h0,        32'hFFFFCAFE, 1'b0, 1'b1, 4'b0000, 32'h0,        3);
    vecs[14] = mk(1'b0, 3'b010, 32'h22, 32'h0,        32'h0,        1'b1, 1'b0, 4'b0000, 32'h0,        1);
    vecs[15] = mk(1'b1, 3'b001, 32'h31, 32'hFFFF,     32'h0,        1'b1, 1'b0, 4'b0000, 32'h0,        1);
    vecs[16] = mk(1'b0, 3'b011, 32'h30, 32'h0,        32'h0,        1'b1, 1'b0, 4'b0000, 32'h0,        1);
    vecs[17] = mk(1'b1, 3'b011, 32'h30, 32'h55,       32'h0,        1'b1, 1'b0, 4'b0000, 32'h0,        1);
    vecs[18] = mk(1'b0, 3'b001, 32'h11, 32'h0,        32'h0,        1'b1, 1'b0, 4'b0000, 32'h0,        1);
    vecs[19] = mk(1'b0, 3'b110, 32'h30, 32'h0,        32'h0,        1'b1, 1'b0, 4'b0000, 32'h0,        1);
    vecs[20] = mk(1'b1, 3'b100, 32'h30, 32'h77,       32'h0,        1'b1, 1'b0, 4'b0000, 32'h0,        1);
    vecs[21] = mk(1'b0, 3'b101, 32'h13, 32'h0,        32'h0,        1'b1, 1'b0, 4'b0000, 32'h0,        1);

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_strobes", {27'd0, mem_rd_strobe, mem_wr_strobe}, 32'd0);
    rst = 1'b0;
    #1;
    check("rst_release_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);

    for (int i = 0; i < 22; i++) run_vec(vecs[i], i);

    // Back-to-back SW then LW with req_valid held high throughout.
    wait_ready("b2b");
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h40; req_wdata = 32'hDEADBEEF;
    n_acc = 0; first = -1; second = -1; resp_st = -1; resp_ld = -1; nresp = 0; ld_data = 32'd0;
    for (int c = 0; c < 14; c++) begin
      if (n_acc == 1) begin
        req_we = 1'b0; req_addr = 32'h40; req_wdata = 32'd0;
      end
      if (n_acc == 2 && c > second) req_valid = 1'b0;
      if (resp_valid) begin
        nresp++;
        if (n_acc == 1) resp_st = c;
        else if (n_acc == 2) begin
          resp_ld = c;
          ld_data = resp_rdata;
        end
      end
      if (req_ready && req_valid) begin
        n_acc++;
        if (n_acc == 1) first = c;
        else if (n_acc == 2) second = c;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("b2b_accepts", n_acc, 2);
    check("b2b_spacing", second - first, 3);
    check("b2b_store_resp_cycle", resp_st - first, 2);
    check("b2b_load_resp_cycle", resp_ld - second, 3);
    check("b2b_resp_count", nresp, 2);
    check("b2b_load_data", ld_data, 32'hDEADBEEF);

    // Asynchronous reset during ISSUE (p=1), WAIT (p=2) and DONE (p=3) of LW @0x10.
    for (int p = 1; p <= 3; p++) begin
      string nm;
      int    seen;
      nm = $sformatf("arst%0d", p);
      wait_ready(nm);
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      for (int k = 1; k < p; k++) @(negedge clk);
      if (p == 1) check({nm, "_pre_rd_strobe"}, {31'd0, mem_rd_strobe}, 32'd1);
      if (p == 3) check({nm, "_pre_rdata"}, resp_rdata, 32'h8899AABB);
      #2;
      rst = 1'b1;
      #1;
      check({nm, "_req_ready"}, {31'd0, req_ready}, 32'd0);
      check({nm, "_strobes"}, {27'd0, mem_rd_strobe, mem_wr_strobe}, 32'd0);
      check({nm, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
      check({nm, "_resp_rdata"}, resp_rdata, 32'd0);
      check({nm, "_resp_err"}, {31'd0, resp_err}, 32'd0);
      check({nm, "_mem_addr"}, mem_addr, 32'd0);
      check({nm, "_mem_wdata"}, mem_wdata, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check({nm, "_ready_after"}, {31'd0, req_ready}, 32'd1);
      seen = 0;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        if (resp_valid || mem_rd_strobe) seen++;
      end
      check({nm, "_no_resp"}, seen, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
